// File: rtl/issue_select.sv
// issue_select: picks ready entries from an in-order queue window and hands
// them, oldest first, to a set of registered issue ports. State updates on
// the falling edge of clk_ni.
// Optional build macro ISSUE_SELECT_FLUSH_EN adds a flush_i input that
// suppresses grants and empties every issue port.
module issue_select #(
    parameter int  Size      = 16,
    parameter type T         = logic,
    parameter int  Consumers = 2,
    localparam int Width     = $clog2(Size)
) (
    input  logic                 clk_ni,
    input  logic                 rst_i,
`ifdef ISSUE_SELECT_FLUSH_EN
    input  logic                 flush_i,
`endif
    input  logic [Width:0]       size_i,
    input  T                     entry_i [Size],
    input  logic [Size-1:0]      ready_i,
    output logic [Size-1:0]      pop_o,
    output logic [Consumers-1:0] valid_o,
    output T                     data_o [Consumers],
    input  logic [Consumers-1:0] accept_i,
    output logic [31:0]          count_o
);

    logic                 flush;
    logic [Size-1:0]      eligible;
    logic [Size-1:0]      avail;
    logic [Consumers-1:0] free;
    logic [Consumers-1:0] grant_vld;
    logic [Width-1:0]     grant_idx [Consumers];
    logic                 found;
    logic [31:0]          acc_cnt;

`ifdef ISSUE_SELECT_FLUSH_EN
    assign flush = flush_i;
`else
    assign flush = 1'b0;
`endif

    // Slot qualification: inside the occupied window and ready. Because the
    // slot index never reaches Size, an oversized size_i clamps naturally.
    always_comb begin
        eligible = '0;
        for (int s = 0; s < Size; s++) begin
            eligible[s] = ready_i[s] && ((Width+1)'(s) < size_i);
        end
        if (rst_i || flush) begin
            eligible = '0;
        end
    end

    // A port can take a new entry when it is empty or is being drained now.
    always_comb begin
        free    = ~valid_o | accept_i;
        acc_cnt = '0;
        for (int k = 0; k < Consumers; k++) begin
            acc_cnt = acc_cnt + 32'(valid_o[k] & accept_i[k]);
        end
    end

    // Grant allocation: each free port, in ascending order, claims the
    // lowest-index eligible slot not yet claimed by an earlier port.
    // Ineligible holes are simply skipped.
    always_comb begin
        avail     = eligible;
        grant_vld = '0;
        found     = 1'b0;
        for (int k = 0; k < Consumers; k++) begin
            grant_idx[k] = '0;
        end
        for (int k = 0; k < Consumers; k++) begin
            found = 1'b0;
            if (free[k]) begin
                for (int s = 0; s < Size; s++) begin
                    if (!found && avail[s]) begin
                        found        = 1'b1;
                        grant_vld[k] = 1'b1;
                        grant_idx[k] = Width'(s);
                        avail[s]     = 1'b0;
                    end
                end
            end
        end
        pop_o = eligible & ~avail;
    end

    // Port state and accepted-entry counter. Data has no reset: it is only
    // meaningful while the matching valid bit is set.
    always_ff @(negedge clk_ni) begin
        if (rst_i) begin
            valid_o <= '0;
            count_o <= '0;
        end else begin
            count_o <= count_o + acc_cnt;
            for (int k = 0; k < Consumers; k++) begin
                if (flush) begin
                    valid_o[k] <= 1'b0;
                end else if (free[k]) begin
                    valid_o[k] <= grant_vld[k];
                    if (grant_vld[k]) begin
                        data_o[k] <= entry_i[grant_idx[k]];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_issue_select.sv
// Bench for issue_select (Size=16, Consumers=2, 8-bit payload). A queue-based
// reference model predicts pop_o each cycle and the port state after the
// falling edge; predictions go through a scoreboard queue.
module tb_issue_select;

    localparam int SZ = 16;
    localparam int NC = 2;

    typedef struct packed {
        logic [NC-1:0]      v;
        logic [NC-1:0][7:0] d;
        logic [31:0]        cnt;
    } exp_t;

    logic          clk_ni = 1'b1;
    logic          rst_i  = 1'b1;
    logic          flush  = 1'b0;
    logic [4:0]    size_i = '0;
    logic [7:0]    entry_i [SZ];
    logic [SZ-1:0] ready_i = '0;
    logic [SZ-1:0] pop_o;
    logic [NC-1:0] valid_o;
    logic [7:0]    data_o [NC];
    logic [NC-1:0] accept_i = '0;
    logic [31:0]   count_o;

    logic [NC-1:0]      m_valid = '0;
    logic [NC-1:0][7:0] m_data  = '0;
    logic [31:0]        m_count = '0;
    exp_t               exp_q [$];

    int n_chk = 0;
    int n_err = 0;

    always #5 clk_ni = ~clk_ni;

    issue_select #(.Size(SZ), .T(logic [7:0]), .Consumers(NC)) dut (
        .clk_ni   (clk_ni),
        .rst_i    (rst_i),
`ifdef ISSUE_SELECT_FLUSH_EN
        .flush_i  (flush),
`endif
        .size_i   (size_i),
        .entry_i  (entry_i),
        .ready_i  (ready_i),
        .pop_o    (pop_o),
        .valid_o  (valid_o),
        .data_o   (data_o),
        .accept_i (accept_i),
        .count_o  (count_o)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One cycle: predict, check combinational pop, cross the falling edge,
    // then compare the registered state with the scoreboard entry.
    task automatic step(input string tag);
        int   elig [$];
        int   s;
        exp_t e;
        logic [SZ-1:0] ep;
        #1;
        ep = '0;
        if (!rst_i && !flush) begin
            for (int i = 0; i < SZ; i++) begin
                if (i < int'(size_i) && ready_i[i]) elig.push_back(i);
            end
        end
        e.cnt = rst_i ? 32'd0 : m_count + 32'(m_valid[0] & accept_i[0])
                                        + 32'(m_valid[1] & accept_i[1]);
        e.v = m_valid;
        e.d = m_data;
        for (int k = 0; k < NC; k++) begin
            if (rst_i || flush) begin
                e.v[k] = 1'b0;
            end else if (!m_valid[k] || accept_i[k]) begin
                if (elig.size() > 0) begin
                    s = elig.pop_front();
                    ep[s]  = 1'b1;
                    e.v[k] = 1'b1;
                    e.d[k] = entry_i[s];
                end else begin
                    e.v[k] = 1'b0;
                end
            end
        end
        chk({tag, ".pop"}, 32'(pop_o), 32'(ep));
        exp_q.push_back(e);
        m_valid = e.v;
        m_data  = e.d;
        m_count = e.cnt;
        @(negedge clk_ni);
        #1;
        e = exp_q.pop_front();
        chk({tag, ".valid"}, 32'(valid_o), 32'(e.v));
        chk({tag, ".count"}, count_o, e.cnt);
        for (int k = 0; k < NC; k++) begin
            if (e.v[k]) chk($sformatf("%s.data%0d", tag, k), 32'(data_o[k]), 32'(e.d[k]));
        end
    endtask

    initial begin
        for (int i = 0; i < SZ; i++) entry_i[i] = 8'(8'hA0 + i);

        // reset state
        rst_i = 1'b1;
        step("rst0");
        step("rst1");
        chk("rst.valid_const", 32'(valid_o), 32'd0);
        chk("rst.count_const", count_o, 32'd0);

        // oldest-first with holes: slots 1,3,4 ready in a 5-entry window
        rst_i = 1'b0; size_i = 5'd5; ready_i = 16'h001A; accept_i = 2'b00;
        #1 chk("r032.pop_const", 32'(pop_o), 32'h000A);
        step("r032");
        chk("r032.d0_const", 32'(data_o[0]), 32'hA1);
        chk("r032.d1_const", 32'(data_o[1]), 32'hA3);

        // both ports held: no pops, data stable
        size_i = 5'd16; ready_i = 16'hFFFF; entry_i[0] = 8'h55;
        step("r033h0"); step("r033h1"); step("r033h2");
        chk("r033.hold_const", 32'(data_o[0]), 32'hA1);
        accept_i = 2'b01;
        #1 chk("r033.pop1_const", 32'(pop_o), 32'h0001);
        step("r033acc");
        chk("r033.reload_const", 32'(data_o[0]), 32'h55);

        // window bounds
        accept_i = 2'b11; ready_i = '0;
        step("drain");
        size_i = 5'd2; ready_i = 16'hFFFF; accept_i = 2'b00;
        step("r034sz2");
        accept_i = 2'b11; size_i = 5'd0;
        step("r034sz0");
        size_i = 5'd15; ready_i = 16'h8000; accept_i = 2'b00;
        step("r034sz15");
        size_i = 5'd17;
        step("r034sz17");
        chk("r034.sz17_const", 32'(data_o[0]), 32'hAF);

        // reset mid-operation with both ports valid
        ready_i = 16'hFFFF; size_i = 5'd16; accept_i = 2'b00;
        step("r036fill");
        rst_i = 1'b1;
        step("r036rst");
        rst_i = 1'b0;
        step("r036first");

        // streaming: 10 entries, two per cycle, always accepted
        rst_i = 1'b1; step("r035rst");
        rst_i = 1'b0; accept_i = 2'b11; size_i = 5'd2; ready_i = 16'h0003;
        for (int c = 0; c < 5; c++) begin
            for (int i = 0; i < 2; i++) entry_i[i] = 8'(c * 2 + i);
            step($sformatf("r035s%0d", c));
        end
        size_i = 5'd0;
        step("r035d0"); step("r035d1");
        chk("r035.count_const", count_o, 32'd10);

`ifdef ISSUE_SELECT_FLUSH_EN
        // flush: port0 valid and accepted this cycle
        accept_i = 2'b00; size_i = 5'd1; ready_i = 16'h0001;
        step("r037fill");
        flush = 1'b1; accept_i = 2'b01; ready_i = 16'hFFFF; size_i = 5'd16;
        #1 chk("r037.pop_const", 32'(pop_o), 32'd0);
        step("r037flush");
        chk("r037.count_const", count_o, 32'd11);
        flush = 1'b0;
        step("r037after");
`endif

        // random traffic against the model
        for (int c = 0; c < 60; c++) begin
            size_i   = 5'($urandom_range(0, 17));
            ready_i  = 16'($urandom);
            accept_i = 2'($urandom);
            rst_i    = ($urandom_range(0, 29) == 0);
`ifdef ISSUE_SELECT_FLUSH_EN
            flush    = ($urandom_range(0, 14) == 0);
`endif
            for (int i = 0; i < SZ; i++) entry_i[i] = 8'($urandom);
            step($sformatf("rnd%0d", c));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
